// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Define YSYX_23060251_ARB_RR_EN for round-robin grant; default is fixed LS-over-IF priority.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_valid_i,
  output logic                if_req_ready_o,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_rsp_valid_o,
  input  logic                if_rsp_ready_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                ls_req_valid_i,
  output logic                ls_req_ready_o,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic                ls_wen_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_wmask_i,
  output logic                ls_rsp_valid_o,
  input  logic                ls_rsp_ready_i,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_wen_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_rsp_valid_i,
  output logic                mem_rsp_ready_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int MW = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_e;

  state_e            state_q;
  logic              owner_q;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MW-1:0]     wmask_q;

  logic grant_ls;
  logic idle;
  logic in_rsp;
  logic own_rdy;

  // owner_q / last_q: 1 = LS, 0 = IF
`ifdef YSYX_23060251_ARB_RR_EN
  assign grant_ls = ls_req_valid_i & (~if_req_valid_i | ~last_q);
`else
  logic unused_last;
  assign unused_last = last_q;
  assign grant_ls    = ls_req_valid_i;
`endif

  assign idle    = (state_q == IDLE) & ~rst_i;
  assign in_rsp  = (state_q == RSP);
  assign own_rdy = owner_q ? ls_rsp_ready_i : if_rsp_ready_i;

  assign ls_req_ready_o = idle & grant_ls;
  assign if_req_ready_o = idle & ~grant_ls & if_req_valid_i;

  assign mem_req_valid_o = (state_q == REQ);
  assign mem_addr_o      = addr_q;
  assign mem_wen_o       = wen_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_wmask_o     = wmask_q;

  // Outside RSP any response is a stale one and is silently drained
  assign mem_rsp_ready_o = in_rsp ? own_rdy : 1'b1;

  assign if_rsp_valid_o = in_rsp & ~owner_q & mem_rsp_valid_i;
  assign ls_rsp_valid_o = in_rsp & owner_q & mem_rsp_valid_i;
  assign if_rdata_o     = mem_rdata_i;
  assign ls_rdata_o     = mem_rdata_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ls_req_ready_o) begin
            owner_q <= 1'b1;
            last_q  <= 1'b1;
            addr_q  <= ls_addr_i;
            wen_q   <= ls_wen_i;
            wdata_q <= ls_wdata_i;
            wmask_q <= ls_wen_i ? ls_wmask_i : '0;
            state_q <= REQ;
          end else if (if_req_ready_o) begin
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= if_addr_i;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready_i) state_q <= RSP;
        end
        RSP: begin
          if (mem_rsp_valid_i && own_rdy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
